// File: rtl/serial_data_xmit.sv
// Serial frame transmitter: start(1), 8 data bits LSB first, parity, stop(0); idle level 0.
// A one-entry holding buffer lets a byte be accepted mid-frame so frames run back to back.
module serial_data_xmit #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_DATA,
  input  logic       I_VALID,
  input  logic       I_FORCE_PERR,
  output logic       O_READY,
  output logic       O_SERIAL_DATA,
  output logic       O_BUSY,
  output logic       O_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam bit         ONE_CLK  = (CLKS_PER_BIT == 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic       buf_full_q;
  logic [7:0] buf_data_q;
  logic       buf_par_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic       ser_q;
  logic       done_q;

  logic eob;
  logic hs;
  logic last_stop;
  logic load_direct;
  logic load_buf;
  logic fill_buf;
  logic shift_en;
  logic done_d;

  function automatic logic frame_parity(input logic [7:0] data, input logic force_err);
    return (^data) ^ force_err;
  endfunction

  assign eob       = (cnt_q == LAST_CNT);
  assign hs        = I_VALID && !buf_full_q;
  assign last_stop = (state_q == S_STOP) && eob;

  // A byte goes straight to the shifter when the line is free now or frees at this edge.
  assign load_direct = hs && ((state_q == S_IDLE) || (last_stop && !buf_full_q));
  assign load_buf    = last_stop && buf_full_q;
  assign fill_buf    = hs && !load_direct;
  assign shift_en    = (state_q == S_DATA) && eob && (bit_idx_q != 3'd7);

  // Registered done lands in the final stop cycle, so decode the cycle just before it.
  assign done_d = ONE_CLK ? ((state_q == S_PARITY) && eob)
                          : ((state_q == S_STOP) && !eob && ((cnt_q + 8'd1) == LAST_CNT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      buf_full_q <= 1'b0;
      ser_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_d;

      if (load_buf) begin
        buf_full_q <= 1'b0;
      end else if (fill_buf) begin
        buf_full_q <= 1'b1;
      end

      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (load_direct) begin
          state_q <= S_START;
          ser_q   <= 1'b1;
        end
      end else if (!eob) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          S_START: begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            ser_q     <= shift_q[0];
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
              state_q <= S_PARITY;
              ser_q   <= par_q;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              ser_q     <= shift_q[1];
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            ser_q   <= 1'b0;
          end
          S_STOP: begin
            if (load_buf || load_direct) begin
              state_q <= S_START;
              ser_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              ser_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            ser_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Payload registers carry no reset; the control path decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (load_direct) begin
      shift_q <= I_DATA;
      par_q   <= frame_parity(I_DATA, I_FORCE_PERR);
    end else if (load_buf) begin
      shift_q <= buf_data_q;
      par_q   <= buf_par_q;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end

    if (fill_buf) begin
      buf_data_q <= I_DATA;
      buf_par_q  <= frame_parity(I_DATA, I_FORCE_PERR);
    end
  end

  assign O_READY       = !buf_full_q;
  assign O_SERIAL_DATA = ser_q;
  assign O_BUSY        = (state_q != S_IDLE);
  assign O_DONE        = done_q;

endmodule

// File: tb/tb_serial_data_xmit.sv
// Bench for serial_data_xmit at one and four clocks per bit, checked against a frame-queue model.
module tb_serial_data_xmit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] d1, d4;
  logic       v1, v4, f1, f4;
  logic       rdy1, ser1, busy1, done1;
  logic       rdy4, ser4, busy4, done4;

  serial_data_xmit #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rstn(rstn), .I_DATA(d1), .I_VALID(v1), .I_FORCE_PERR(f1),
    .O_READY(rdy1), .O_SERIAL_DATA(ser1), .O_BUSY(busy1), .O_DONE(done1)
  );

  serial_data_xmit #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rstn(rstn), .I_DATA(d4), .I_VALID(v4), .I_FORCE_PERR(f4),
    .O_READY(rdy4), .O_SERIAL_DATA(ser4), .O_BUSY(busy4), .O_DONE(done4)
  );

  int nvec = 0;
  int nmis = 0;

  // Model: per-cycle line values still to be shown, {last-cycle-of-frame, level}.
  logic [1:0] mline [2][8192];
  int mhead [2];
  int mtail [2];
  int mbuf  [2];   // cycles until a buffered frame reaches the line (0 = buffer empty)
  int cpb   [2];
  logic acc1, acc4;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0;
      mtail[d] = 0;
      mbuf[d]  = 0;
    end
  endtask

  task automatic m_push(input int d, input logic [7:0] b, input logic f);
    logic [10:0] fr;
    fr = {1'b0, (^b) ^ f, b, 1'b1};
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < cpb[d]; c++) begin
        if (mtail[d] < 8192) mline[d][mtail[d]] = {(k == 10 && c == cpb[d] - 1), fr[k]};
        mtail[d]++;
      end
    end
  endtask

  function automatic logic m_busy(input int d);
    return mhead[d] < mtail[d];
  endfunction

  function automatic logic m_line(input int d);
    return m_busy(d) ? mline[d][mhead[d]][0] : 1'b0;
  endfunction

  function automatic logic m_done(input int d);
    return m_busy(d) ? mline[d][mhead[d]][1] : 1'b0;
  endfunction

  function automatic logic m_ready(input int d);
    return mbuf[d] == 0;
  endfunction

  task automatic m_edge(input int d, input logic hs, input logic [7:0] b, input logic f);
    if (m_busy(d)) mhead[d]++;
    if (mbuf[d] > 0) mbuf[d]--;
    if (hs) begin
      if (m_busy(d)) mbuf[d] = mtail[d] - mhead[d];
      m_push(d, b, f);
    end
  endtask

  // One clock: compare outputs, advance the model across the rising edge, return at negedge.
  task automatic tick();
    logic hs1, hs4;
    logic [7:0] b1, b4;
    logic e1, e4;
    chk("ready1", 16'(rdy1),  16'(m_ready(0)));
    chk("line1",  16'(ser1),  16'(m_line(0)));
    chk("busy1",  16'(busy1), 16'(m_busy(0)));
    chk("done1",  16'(done1), 16'(m_done(0)));
    chk("ready4", 16'(rdy4),  16'(m_ready(1)));
    chk("line4",  16'(ser4),  16'(m_line(1)));
    chk("busy4",  16'(busy4), 16'(m_busy(1)));
    chk("done4",  16'(done4), 16'(m_done(1)));
    hs1 = v1 && m_ready(0);
    hs4 = v4 && m_ready(1);
    b1 = d1; e1 = f1; b4 = d4; e4 = f4;
    @(posedge clk);
    m_edge(0, hs1, b1, e1);
    m_edge(1, hs4, b4, e4);
    acc1 = hs1;
    acc4 = hs4;
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] cap;
    logic [7:0]  bb [3];
    int ndone1, ndone4, nbusy4, nbusy1, run, maxrun, nnotrdy, k;

    cpb[0] = 1;
    cpb[1] = 4;
    bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h03;
    m_reset();
    rstn = 1'b0;
    v1 = 1'b0; d1 = 8'h00; f1 = 1'b0;
    v4 = 1'b0; d4 = 8'h00; f4 = 1'b0;

    // Reset state while rstn is held low.
    repeat (2) @(negedge clk);
    chk("rst_line1",  16'(ser1),  16'd0);
    chk("rst_busy1",  16'(busy1), 16'd0);
    chk("rst_done1",  16'(done1), 16'd0);
    chk("rst_ready1", 16'(rdy1),  16'd1);
    chk("rst_line4",  16'(ser4),  16'd0);
    rstn = 1'b1;

    // 0xA5 at one clock per bit and 0x3C at four, accepted on the first edge after release.
    v1 = 1'b1; d1 = 8'hA5; v4 = 1'b1; d4 = 8'h3C;
    tick();
    chk("a5_accept", 16'(acc1), 16'd1);
    v1 = 1'b0; v4 = 1'b0;
    cap = '0; ndone1 = 0; ndone4 = 0; nbusy4 = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 11) cap = {cap[9:0], ser1};
      ndone1 += int'(done1);
      ndone4 += int'(done4);
      nbusy4 += int'(busy4);
      tick();
    end
    chk("a5_frame",   16'(cap),    16'(11'b11010010100));
    chk("a5_done",    16'(ndone1), 16'd1);
    chk("3c_busy",    16'(nbusy4), 16'd44);
    chk("3c_done",    16'(ndone4), 16'd1);

    // Forced parity error on 0x07: parity bit flips from 1 to 0.
    v1 = 1'b1; d1 = 8'h07; f1 = 1'b1;
    tick();
    v1 = 1'b0; f1 = 1'b0;
    cap = '0;
    for (int i = 0; i < 11; i++) begin
      cap = {cap[9:0], ser1};
      tick();
    end
    chk("perr_frame", 16'(cap), 16'(11'b11110000000));
    repeat (3) tick();

    // Back-to-back frames with valid held high.
    k = 0; nbusy1 = 0; run = 0; maxrun = 0; nnotrdy = 0;
    for (int i = 0; i < 40; i++) begin
      v1 = (k < 3);
      d1 = bb[(k < 3) ? k : 0];
      nbusy1  += int'(busy1);
      nnotrdy += int'(!rdy1);
      run = busy1 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      tick();
      if (acc1) k++;
    end
    v1 = 1'b0;
    chk("b2b_accepted", 16'(k),       16'd3);
    chk("b2b_busy",     16'(nbusy1),  16'd33);
    chk("b2b_run",      16'(maxrun),  16'd33);
    chk("b2b_notready", 16'(nnotrdy), 16'd20);

    // Reset during D[3] with a byte buffered.
    v1 = 1'b1; d1 = 8'($urandom);
    tick();
    d1 = 8'($urandom);
    tick();
    v1 = 1'b0;
    repeat (3) tick();
    chk("mid_buffered", 16'(rdy1), 16'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_line",  16'(ser1),  16'd0);
    chk("mid_rst_busy",  16'(busy1), 16'd0);
    chk("mid_rst_done",  16'(done1), 16'd0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    chk("mid_rel_ready", 16'(rdy1), 16'd1);
    repeat (30) tick();

    // Handshake on the very first edge after a reset release.
    rstn = 1'b0;
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    v1 = 1'b1; d1 = 8'h5A;
    tick();
    chk("first_edge_accept", 16'(acc1), 16'd1);
    v1 = 1'b0;
    repeat (14) tick();

    // Randomised traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      v1 = ($urandom_range(0, 99) < 60);
      d1 = 8'($urandom);
      f1 = ($urandom_range(0, 9) == 0);
      v4 = ($urandom_range(0, 99) < 40);
      d4 = 8'($urandom);
      f4 = ($urandom_range(0, 9) == 0);
      tick();
    end
    v1 = 1'b0; v4 = 1'b0; f1 = 1'b0; f4 = 1'b0;
    repeat (100) tick();
    chk("drain_busy1", 16'(busy1), 16'd0);
    chk("drain_busy4", 16'(busy4), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/serial_data_xmit.md
SERIAL_DATA_XMIT -- requirements
Module: serial_data_xmit

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port I_DATA  input  8  byte to send, sampled on handshake.
REQ-005 SHALL have port I_VALID  input  1  I_DATA is valid.
REQ-006 SHALL have port I_FORCE_PERR  input  1  when sampled high with a byte, that frame's parity bit is inverted (receiver error-path test).
REQ-007 SHALL have port O_READY  output  1  byte can be accepted this cycle.
REQ-008 SHALL have port O_SERIAL_DATA  output  1  serial line, registered.
REQ-009 SHALL have port O_BUSY  output  1  a frame is on the line (state != IDLE).
REQ-010 SHALL have port O_DONE  output  1  one-cycle pulse in the last cycle of a stop bit.

Function
REQ-011 Frame SHALL be 11 bits: start bit = 1, D[0]..D[7] LSB first, parity = XOR of D[7:0] (even parity, inverted if forced), stop bit = 0; idle line level = 0.
REQ-012 Each bit SHALL be held on O_SERIAL_DATA for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions only at the end of a bit period except IDLE->START.
REQ-014 DATA SHALL use a 3-bit bit index 0..7; DATA->PARITY after index 7's period completes.
REQ-015 Handshake SHALL occur on a rising edge where I_VALID && O_READY; the byte and I_FORCE_PERR are captured together.
REQ-016 A one-entry holding buffer SHALL exist; O_READY = !buffer_full (combinational from the register).
REQ-017 Handshake while IDLE SHALL load the shift register directly (buffer stays empty); the start bit appears on O_SERIAL_DATA the cycle after the handshake.
REQ-018 Handshake while not IDLE SHALL fill the buffer, except in the last STOP cycle with buffer empty, where it loads the shift register directly.
REQ-019 At the end of STOP: if buffer full, SHALL move its contents into the shift register, empty the buffer and enter START (gapless back-to-back frames); else a direct load per REQ-018 enters START; otherwise IDLE.
REQ-020 Buffer full and handshake attempted SHALL be impossible (O_READY=0); I_DATA ignored while O_READY=0.
REQ-021 Parity SHALL be computed at load time from the captured byte, not accumulated on the line.
REQ-022 O_DONE SHALL assert exactly once per frame, in the final cycle of the stop bit, concurrent with O_SERIAL_DATA=0.
REQ-023 I_VALID held high with O_READY=1 in IDLE SHALL yield continuous frames with no idle cycles between them.

Reset
REQ-024 rstn low SHALL immediately force: state IDLE, O_SERIAL_DATA=0, O_BUSY=0, O_DONE=0, buffer empty, counters 0; O_READY=1 once rstn deasserts.
REQ-025 Reset mid-frame SHALL abort the frame and discard any buffered byte; no partial-frame completion after release.
REQ-026 First handshake SHALL be honoured on the first rising edge after rstn deasserts.

Verification
REQ-027 CLKS_PER_BIT=1, send 0xA5 from IDLE -> line from next cycle: 1,1,0,1,0,0,1,0,1,0,0; O_DONE high in cycle 11; O_BUSY high for 11 cycles.
REQ-028 CLKS_PER_BIT=1, send 0x07 with I_FORCE_PERR=1 -> parity bit 0 instead of 1; all other bits unchanged.
REQ-029 CLKS_PER_BIT=4, send 0x3C -> each of the 11 bits held 4 cycles (44 cycles), parity 0, one O_DONE pulse.
REQ-030 CLKS_PER_BIT=1, I_VALID held high with bytes 0x01,0x02,0x03 -> three frames, 33 contiguous cycles, no idle 0 between the stop bit and the next start bit, O_READY low while buffer full.
REQ-031 Assert rstn=0 during D[3] of a frame with a byte buffered -> O_SERIAL_DATA=0 immediately, O_READY=1 after release, line stays 0 with no further frames until a new handshake.
REQ-032 Loopback into the existing serial receiver at CLKS_PER_BIT=1 -> no O_ERROR for clean frames; O_ERROR pulse for each I_FORCE_PERR frame.
